// File: rtl/div_issue_queue.sv
// In-order issue queue for divide/remainder uops. Holds up to 1<<LG_DEPTH entries
// and launches the head into the iterative divider whenever no divide is in flight.
`ifndef M_WIDTH
`define M_WIDTH 32
`endif
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 5
`endif
`ifndef LG_PRF_ENTRIES
`define LG_PRF_ENTRIES 6
`endif

module div_issue_queue #(
   parameter int LG_DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       enq_valid,
   output logic                       enq_ready,
   input  logic [`M_WIDTH-1:0]        enq_srcA,
   input  logic [`M_WIDTH-1:0]        enq_srcB,
   input  logic [`LG_ROB_ENTRIES-1:0] enq_rob_ptr,
   input  logic [`LG_PRF_ENTRIES-1:0] enq_prf_ptr,
   input  logic                       enq_is_signed,
   input  logic                       enq_is_rem,
   output logic                       div_start,
   output logic [`M_WIDTH-1:0]        div_inA,
   output logic [`M_WIDTH-1:0]        div_inB,
   output logic [`LG_ROB_ENTRIES-1:0] div_rob_ptr,
   output logic [`LG_PRF_ENTRIES-1:0] div_prf_ptr,
   output logic                       div_is_signed,
   output logic                       div_is_rem,
   input  logic                       div_complete,
   output logic                       busy,
   output logic [LG_DEPTH:0]          count
);

   localparam int               DEPTH = 1 << LG_DEPTH;
   localparam logic [LG_DEPTH:0] FULL = (LG_DEPTH + 1)'(DEPTH);

   typedef struct packed {
      logic [`M_WIDTH-1:0]        src_a;
      logic [`M_WIDTH-1:0]        src_b;
      logic [`LG_ROB_ENTRIES-1:0] rob_ptr;
      logic [`LG_PRF_ENTRIES-1:0] prf_ptr;
      logic                       is_signed;
      logic                       is_rem;
   } entry_t;

   entry_t                mem [DEPTH];
   entry_t                enq_entry;
   entry_t                head_entry;
   logic [LG_DEPTH-1:0]   head;
   logic [LG_DEPTH-1:0]   tail;
   logic [LG_DEPTH:0]     r_count;
   logic                  r_busy;
   logic                  do_enq;

   // Launch depends only on local state and flush, never on the divider's ready.
   assign enq_ready = (r_count != FULL);
   assign do_enq    = enq_valid & enq_ready & ~flush;
   assign div_start = (r_count != '0) & ~r_busy & ~flush;
   assign count     = r_count;
   assign busy      = r_busy;

   assign enq_entry  = '{enq_srcA, enq_srcB, enq_rob_ptr, enq_prf_ptr, enq_is_signed, enq_is_rem};
   assign head_entry = mem[head];

   assign div_inA       = head_entry.src_a;
   assign div_inB       = head_entry.src_b;
   assign div_rob_ptr   = head_entry.rob_ptr;
   assign div_prf_ptr   = head_entry.prf_ptr;
   assign div_is_signed = head_entry.is_signed;
   assign div_is_rem    = head_entry.is_rem;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         r_count <= '0;
         r_busy  <= 1'b0;
      end else begin
         if (flush) begin
            head    <= '0;
            tail    <= '0;
            r_count <= '0;
         end else begin
            if (do_enq)    tail <= tail + 1'b1;
            if (div_start) head <= head + 1'b1;
            case ({do_enq, div_start})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
         // Flush leaves an in-flight divide alone; its result is dropped by ROB tag.
         if (div_start)         r_busy <= 1'b1;
         else if (div_complete) r_busy <= 1'b0;
      end
   end

   // NOTE: payload storage has no reset; entries are only read once counted valid,
   // so clearing them would add reset fan-out for no functional gain.
   always_ff @(posedge clk) begin
      if (do_enq) mem[tail] <= enq_entry;
   end

endmodule

// File: tb/tb_div_issue_queue.sv
// Self-checking bench for div_issue_queue: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
`ifndef M_WIDTH
`define M_WIDTH 32
`endif
`ifndef LG_ROB_ENTRIES
`define LG_ROB_ENTRIES 5
`endif
`ifndef LG_PRF_ENTRIES
`define LG_PRF_ENTRIES 6
`endif

module tb_div_issue_queue;

   localparam int LG_DEPTH = 2;
   localparam int DEPTH    = 1 << LG_DEPTH;
   localparam int MW       = `M_WIDTH;
   localparam int RW       = `LG_ROB_ENTRIES;
   localparam int PW       = `LG_PRF_ENTRIES;

   logic          clk = 1'b0;
   logic          reset, flush, enq_valid, enq_ready;
   logic [MW-1:0] enq_srcA, enq_srcB, div_inA, div_inB;
   logic [RW-1:0] enq_rob_ptr, div_rob_ptr;
   logic [PW-1:0] enq_prf_ptr, div_prf_ptr;
   logic          enq_is_signed, enq_is_rem, div_start, div_is_signed, div_is_rem;
   logic          div_complete, busy;
   logic [LG_DEPTH:0] count;

   div_issue_queue #(.LG_DEPTH(LG_DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .enq_valid(enq_valid), .enq_ready(enq_ready),
      .enq_srcA(enq_srcA), .enq_srcB(enq_srcB),
      .enq_rob_ptr(enq_rob_ptr), .enq_prf_ptr(enq_prf_ptr),
      .enq_is_signed(enq_is_signed), .enq_is_rem(enq_is_rem),
      .div_start(div_start), .div_inA(div_inA), .div_inB(div_inB),
      .div_rob_ptr(div_rob_ptr), .div_prf_ptr(div_prf_ptr),
      .div_is_signed(div_is_signed), .div_is_rem(div_is_rem),
      .div_complete(div_complete), .busy(busy), .count(count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [MW-1:0] a;
      logic [MW-1:0] b;
      logic [RW-1:0] rob;
      logic [PW-1:0] prf;
      logic          sg;
      logic          rm;
   } ent_t;

   ent_t mq[$];
   bit   m_busy  = 0;
   bit   m_valid = 0;
   bit   m_st, m_acc;
   ent_t m_e;

   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
         m_busy  = 0;
         m_valid = 1;
      end else if (m_valid) begin
         m_st  = (mq.size() != 0) && !m_busy && !flush;
         m_acc = enq_valid && (mq.size() < DEPTH) && !flush;
         m_e   = '{enq_srcA, enq_srcB, enq_rob_ptr, enq_prf_ptr, enq_is_signed, enq_is_rem};
         if (flush) mq.delete();
         else begin
            if (m_st)  void'(mq.pop_front());
            if (m_acc) mq.push_back(m_e);
         end
         if (m_st)              m_busy = 1;
         else if (div_complete) m_busy = 0;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("enq_ready", 64'(enq_ready), 64'(mq.size() != DEPTH));
         check("count",     64'(count),     64'(mq.size()));
         check("busy",      64'(busy),      64'(m_busy));
         check("div_start", 64'(div_start), 64'((mq.size() != 0) && !m_busy && !flush));
         if (mq.size() != 0) begin
            check("div_inA",       64'(div_inA),       64'(mq[0].a));
            check("div_inB",       64'(div_inB),       64'(mq[0].b));
            check("div_rob_ptr",   64'(div_rob_ptr),   64'(mq[0].rob));
            check("div_prf_ptr",   64'(div_prf_ptr),   64'(mq[0].prf));
            check("div_is_signed", 64'(div_is_signed), 64'(mq[0].sg));
            check("div_is_rem",    64'(div_is_rem),    64'(mq[0].rm));
         end
      end
   end

   // ---------------- divider emulation (stimulus side) ----------------
   int cycle_n = 0;
   int dcnt    = 0;
   int lat     = 34;
   int start_cyc[$];
   int start_rob[$];

   always @(negedge clk) begin
      if (!reset && div_start) begin
         dcnt = lat;
         start_cyc.push_back(cycle_n);
         start_rob.push_back(int'(div_rob_ptr));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      cycle_n++;
      div_complete = 1'b0;
      if (dcnt > 0) begin
         dcnt--;
         if (dcnt == 0) div_complete = 1'b1;
      end
   endtask

   task automatic set_enq(input logic v, input int rob);
      enq_valid     = v;
      enq_srcA      = MW'($urandom);
      enq_srcB      = MW'($urandom);
      enq_rob_ptr   = RW'(rob);
      enq_prf_ptr   = PW'($urandom);
      enq_is_signed = 1'($urandom);
      enq_is_rem    = 1'($urandom);
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (!busy && count == '0 && dcnt == 0) begin ok = 1; break; end
         cyc();
      end
      check("wait_idle_timeout", 64'(ok), 64'(1));
      cyc();
   endtask

   int base;
   bit found;

   initial begin
      reset = 1; flush = 0; div_complete = 0;
      set_enq(0, 0);
      cyc(); cyc();

      // Single uop: 100 / 7, rob 3, prf 9, unsigned quotient.
      reset = 0;
      enq_valid = 1; enq_srcA = 100; enq_srcB = 7; enq_rob_ptr = 3; enq_prf_ptr = 9;
      enq_is_signed = 0; enq_is_rem = 0;
      @(negedge clk);
      check("rst_count", 64'(count), 64'(0));
      check("rst_enq_ready", 64'(enq_ready), 64'(1));
      check("rst_div_start", 64'(div_start), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      cyc(); enq_valid = 0;
      @(negedge clk);
      check("single_start", 64'(div_start), 64'(1));
      check("single_inA", 64'(div_inA), 64'(100));
      check("single_inB", 64'(div_inB), 64'(7));
      check("single_rob", 64'(div_rob_ptr), 64'(3));
      check("single_prf", 64'(div_prf_ptr), 64'(9));
      check("single_rem", 64'(div_is_rem), 64'(0));
      cyc();
      @(negedge clk);
      check("single_busy_c2", 64'(busy), 64'(1));
      repeat (33) cyc();
      @(negedge clk);
      check("single_complete_c35", 64'(div_complete), 64'(1));
      check("single_busy_c35", 64'(busy), 64'(1));
      cyc();
      @(negedge clk);
      check("single_busy_c36", 64'(busy), 64'(0));
      check("single_count_c36", 64'(count), 64'(0));
      wait_idle();

      // Back-to-back: four uops, starts 35 cycles apart in enqueue order.
      start_cyc.delete(); start_rob.delete();
      for (int i = 0; i < 4; i++) begin
         if (i != 0) cyc();
         set_enq(1, i);
         if (i == 0) base = cycle_n;
      end
      cyc(); enq_valid = 0;
      repeat (145) cyc();
      check("b2b_nstarts", 64'(start_cyc.size()), 64'(4));
      for (int i = 0; i < 4 && i < start_cyc.size(); i++) begin
         check("b2b_start_cycle", 64'(start_cyc[i] - base), 64'(1 + 35 * i));
         check("b2b_start_rob", 64'(start_rob[i]), 64'(i));
      end
      wait_idle();

      // Full queue with a launch pending: enqueue must still be refused.
      for (int i = 0; i < 5; i++) begin
         if (i != 0) cyc();
         set_enq(1, 8 + i);
      end
      cyc(); set_enq(1, 13);
      found = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (div_start) begin found = 1; break; end
         cyc();
      end
      check("full_start_seen", 64'(found), 64'(1));
      check("full_enq_ready", 64'(enq_ready), 64'(0));
      check("full_count", 64'(count), 64'(4));
      cyc(); enq_valid = 0;
      @(negedge clk);
      check("full_count_after", 64'(count), 64'(3));
      check("full_busy_after", 64'(busy), 64'(1));

      // Flush with a divide in flight and an enqueue offered.
      cyc(); flush = 1; set_enq(1, 14);
      @(negedge clk);
      check("flush_start_suppressed", 64'(div_start), 64'(0));
      cyc(); flush = 0; enq_valid = 0;
      @(negedge clk);
      check("flush_count", 64'(count), 64'(0));
      check("flush_busy_held", 64'(busy), 64'(1));
      found = 0;
      for (int k = 0; k < 100; k++) begin
         cyc();
         @(negedge clk);
         if (!busy) begin found = 1; break; end
      end
      check("flush_busy_clears", 64'(found), 64'(1));
      check("flush_no_start", 64'(div_start), 64'(0));
      wait_idle();

      // Flush coincident with a launch opportunity.
      set_enq(1, 20);
      cyc(); enq_valid = 0; flush = 1;
      @(negedge clk);
      check("flush_launch_count", 64'(count), 64'(1));
      check("flush_launch_start", 64'(div_start), 64'(0));
      cyc(); flush = 0;
      @(negedge clk);
      check("flush_launch_count_after", 64'(count), 64'(0));
      check("flush_launch_busy", 64'(busy), 64'(0));

      // Reset mid-flight.
      cyc(); set_enq(1, 21);
      cyc(); set_enq(1, 22);
      cyc(); set_enq(1, 23);
      cyc(); enq_valid = 0; reset = 1; dcnt = 0;
      @(negedge clk);
      check("rmid_pre_busy", 64'(busy), 64'(1));
      check("rmid_pre_count", 64'(count), 64'(2));
      cyc(); reset = 0; set_enq(1, 24);
      @(negedge clk);
      check("rmid_count", 64'(count), 64'(0));
      check("rmid_busy", 64'(busy), 64'(0));
      check("rmid_enq_ready", 64'(enq_ready), 64'(1));
      check("rmid_start", 64'(div_start), 64'(0));
      cyc(); enq_valid = 0;
      @(negedge clk);
      check("rmid_fresh_start", 64'(div_start), 64'(1));
      check("rmid_fresh_rob", 64'(div_rob_ptr), 64'(24));
      wait_idle();

      // Randomized traffic with short divider latencies.
      for (int n = 0; n < 3000; n++) begin
         cyc();
         lat   = $urandom_range(1, 8);
         reset = ($urandom_range(0, 199) == 0);
         if (reset) dcnt = 0;
         flush = ($urandom_range(0, 19) == 0);
         set_enq($urandom_range(0, 9) < 6, $urandom_range(0, (1 << RW) - 1));
         if (dcnt == 0 && $urandom_range(0, 29) == 0) div_complete = 1'b1;
      end
      cyc();
      reset = 0; flush = 0; enq_valid = 0;
      lat = 34;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
